// File: rtl/tcdm_copy_engine_pkg.sv
// Shared constants for the TCDM copy engine: FSM encoding and default sizes.
package tcdm_copy_engine_pkg;

  localparam int unsigned TCDM_COPY_FIFO_DEPTH = 4;
  localparam int unsigned TCDM_COPY_LEN_W      = 16;

  // FSM encoding kept as plain constants for legacy tool compatibility
  localparam int unsigned TCDM_COPY_STATE_W = 2;
  typedef logic [TCDM_COPY_STATE_W-1:0] tcdm_copy_state_t;

  localparam tcdm_copy_state_t TCDM_COPY_IDLE = 2'd0;
  localparam tcdm_copy_state_t TCDM_COPY_RUN  = 2'd1;
  localparam tcdm_copy_state_t TCDM_COPY_DONE = 2'd2;

endpackage

// File: rtl/tcdm_copy_fifo.sv
// Synchronous read-data FIFO for the copy engine. Exposes the head and the
// entry behind it so the engine can pre-load the next write while popping.
module tcdm_copy_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_o,
  output logic [DW-1:0]            second_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Accept a push when there is room (or a pop frees a slot); pop only when data exists
  always_comb begin
    push_ok  = push_i && (!full_o || pop_i);
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; contents are only meaningful behind a valid count
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign second_o = mem_q[rd_ptr_q + PW'(1)];
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

endmodule

// File: rtl/tcdm_copy_engine.sv
// TCDM copy engine: moves len_i words from src to dst through one HCI core
// port, buffering read data in a small FIFO so several reads stay in flight.
// Optional stall counter enabled by defining TCDM_COPY_PERF_EN.
module tcdm_copy_engine
  import tcdm_copy_engine_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = TCDM_COPY_FIFO_DEPTH,
  parameter int unsigned LEN_W      = TCDM_COPY_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [AW-1:0]     src_addr_i,
  input  logic [AW-1:0]     dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [AW-1:0]     tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [DW/8-1:0]   tcdm_be_o,
  output logic [DW-1:0]     tcdm_data_o,
  input  logic [DW-1:0]     tcdm_r_data_i,
  input  logic              tcdm_r_valid_i,
  output logic [31:0]       stall_cnt_o
);

  localparam int unsigned WORD_SIZE = DW / 8;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] WORD_INC   = AW'(WORD_SIZE);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(WORD_SIZE - 1);

  tcdm_copy_state_t state_q, state_d;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic             inflight_q, inflight_d;
  logic             req_q, req_d;
  logic [AW-1:0]    add_q, add_d;
  logic             wen_q, wen_d;
  logic [DW-1:0]    data_q, data_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             grant, rd_gnt, wr_gnt, push, pop, can_issue, credit_ok;
  logic [AW-1:0]    src_n, dst_n;
  logic [LEN_W-1:0] rd_left_n, wr_left_n;
  logic [CW-1:0]    cnt_n;
  logic [CW:0]      credit_use;
  logic [DW-1:0]    head_n;

  logic [DW-1:0]    fifo_head, fifo_second;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;

  tcdm_copy_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push),
    .data_i   (tcdm_r_data_i),
    .pop_i    (pop),
    .head_o   (fifo_head),
    .second_o (fifo_second),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  // Handshake events of this cycle and the view of the state right after them
  always_comb begin
    grant     = req_q && tcdm_gnt_i;
    rd_gnt    = grant && wen_q;
    wr_gnt    = grant && !wen_q;
    // Responses are only taken when the previous grant was a read
    push      = tcdm_r_valid_i && inflight_q;
    pop       = wr_gnt;
    can_issue = !req_q || grant;
    src_n     = rd_gnt ? src_q + WORD_INC : src_q;
    dst_n     = wr_gnt ? dst_q + WORD_INC : dst_q;
    rd_left_n = rd_gnt ? rd_left_q - LEN_W'(1) : rd_left_q;
    wr_left_n = wr_gnt ? wr_left_q - LEN_W'(1) : wr_left_q;
    cnt_n     = fifo_cnt + CW'(push) - CW'(pop);
    // Reads still owed to the FIFO count against its capacity
    credit_use = {1'b0, cnt_n} + (CW+1)'(rd_gnt);
    credit_ok  = (credit_use < (CW+1)'(FIFO_DEPTH)) && !fifo_full;
    // Word that will sit at the FIFO head after this cycle's push/pop
    if (pop) head_n = (fifo_cnt > CW'(1)) ? fifo_second : tcdm_r_data_i;
    else     head_n = !fifo_empty ? fifo_head : tcdm_r_data_i;
  end

  // Next-state and request generation; one request at a time, held until granted
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    inflight_d = rd_gnt;
    req_d      = req_q;
    add_d      = add_q;
    wen_d      = wen_q;
    data_d     = data_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      TCDM_COPY_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d   = TCDM_COPY_RUN;
            busy_d    = 1'b1;
            src_d     = src_addr_i & ALIGN_MASK;
            dst_d     = dst_addr_i & ALIGN_MASK;
            rd_left_d = len_i;
            wr_left_d = len_i;
            // FIFO is empty, so the first request is always a read
            req_d     = 1'b1;
            wen_d     = 1'b1;
            add_d     = src_addr_i & ALIGN_MASK;
          end else begin
            state_d = TCDM_COPY_DONE;
            done_d  = 1'b1;
          end
        end
      end

      TCDM_COPY_RUN: begin
        busy_d    = 1'b1;
        src_d     = src_n;
        dst_d     = dst_n;
        rd_left_d = rd_left_n;
        wr_left_d = wr_left_n;
        if (wr_gnt && (wr_left_q == LEN_W'(1))) begin
          state_d = TCDM_COPY_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          req_d   = 1'b0;
        end else if (can_issue) begin
          req_d = 1'b0;
          if (cnt_n != '0) begin
            req_d  = 1'b1;
            wen_d  = 1'b0;
            add_d  = dst_n;
            data_d = head_n;
          end else if ((rd_left_n != '0) && credit_ok) begin
            req_d = 1'b1;
            wen_d = 1'b1;
            add_d = src_n;
          end
        end
      end

      TCDM_COPY_DONE: begin
        state_d = TCDM_COPY_IDLE;
      end

      default: begin
        state_d = TCDM_COPY_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Engine state and registered HCI request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= TCDM_COPY_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      inflight_q <= 1'b0;
      req_q      <= 1'b0;
      add_q      <= '0;
      wen_q      <= 1'b1;
      data_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      inflight_q <= inflight_d;
      req_q      <= req_d;
      add_q      <= add_d;
      wen_q      <= wen_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tcdm_req_o  = req_q;
  assign tcdm_add_o  = add_q;
  assign tcdm_wen_o  = wen_q;
  assign tcdm_be_o   = '1;
  assign tcdm_data_o = data_q;

`ifdef TCDM_COPY_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a request waits for grant
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == TCDM_COPY_IDLE) && (state_d == TCDM_COPY_RUN)) begin
      stall_cnt_d = '0;
    end else if (req_q && !tcdm_gnt_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_copy_engine.sv
// Bench for tcdm_copy_engine: a memory/grant responder plus scenario tasks
// comparing destination memory and handshake behaviour with expected copies.
module tb_tcdm_copy_engine;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, tcdm_req_o, tcdm_wen_o;
  logic        tcdm_gnt_i = 1'b0;
  logic [31:0] tcdm_add_o, tcdm_data_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_r_data_i = '0;
  logic        tcdm_r_valid_i = 1'b0;
  logic [31:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  tcdm_copy_engine dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .src_addr_i     (src_addr_i),
    .dst_addr_i     (dst_addr_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .stall_cnt_o    (stall_cnt_o)
  );

  // ---------------- memory / grant responder ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  int gnt_mode = 0;     // 0: always grant, 1: random 50%, 2: three stall cycles per request
  int wait_cnt = 0;
  int proto_err = 0;
  int occ = 0, max_occ = 0;
  int wr_commits = 0, req_cycles = 0;
  logic        p_req = 1'b0, p_gnt = 1'b0, p_wen = 1'b0;
  logic [31:0] p_add = '0, p_data = '0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      p_req = 1'b0; p_gnt = 1'b0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
      wait_cnt = 0; occ = 0;
    end else begin
      tcdm_r_valid_i = 1'b0;
      if (p_req && p_gnt) begin
        if (p_wen) begin
          tcdm_r_valid_i = 1'b1;
          tcdm_r_data_i  = mem.exists(p_add) ? mem[p_add] : 32'hBAD0_0000;
          occ++;
          if (occ > max_occ) max_occ = occ;
        end else begin
          mem[p_add] = p_data;
          wr_commits++;
          occ--;
          tcdm_r_valid_i = 1'b1;          // write response, carries junk
          tcdm_r_data_i  = $urandom;
        end
      end else if (p_req) begin
        if (tcdm_req_o !== 1'b1 || tcdm_add_o !== p_add || tcdm_wen_o !== p_wen ||
            tcdm_data_o !== p_data) proto_err++;
      end
      if (tcdm_req_o) begin
        req_cycles++;
        if (tcdm_be_o !== 4'hF) proto_err++;
      end
      case (gnt_mode)
        0: tcdm_gnt_i = 1'b1;
        1: tcdm_gnt_i = 1'($urandom_range(0, 1));
        default: begin
          if (tcdm_req_o && wait_cnt == 3) begin
            tcdm_gnt_i = 1'b1; wait_cnt = 0;
          end else begin
            tcdm_gnt_i = 1'b0;
            if (tcdm_req_o) wait_cnt++;
          end
        end
      endcase
      p_req = tcdm_req_o; p_gnt = tcdm_gnt_i; p_wen = tcdm_wen_o;
      p_add = tcdm_add_o; p_data = tcdm_data_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
  endfunction

  task automatic fill_src(input logic [31:0] src, input int len);
    logic [31:0] w, a;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      a = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      mem[a] = w;
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_dst(input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) mem.delete((dst & 32'hFFFF_FFFC) + 32'(4 * i));
  endtask

  // Start one transfer and watch until a few cycles past the first done_o
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int mid_at, input int mid_len,
                          output int done_cnt, output int first_done,
                          output bit busy_seen, output bit timed_out);
    int cyc;
    done_cnt = 0; first_done = -1; busy_seen = 1'b0; timed_out = 1'b0;
    @(negedge clk_i);
    src_addr_i = src; dst_addr_i = dst; len_i = 16'(len); start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (1'b1) begin
      if (done_o) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      if (busy_o) busy_seen = 1'b1;
      if (first_done >= 0 && cyc >= first_done + 3) break;
      if (cyc >= 3000) begin timed_out = 1'b1; break; end
      if (cyc == mid_at) begin
        start_i = 1'b1; len_i = 16'(mid_len);
        src_addr_i = 32'h0000_9000; dst_addr_i = 32'h0000_A000;
      end
      @(negedge clk_i);
      start_i = 1'b0;
      cyc++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    total++; if (tcdm_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", tcdm_req_o); end
    total++; if (tcdm_wen_o !== 1'b1) begin bad++; $display("FAIL reset_wen got=%b want=1", tcdm_wen_o); end
    total++; if (tcdm_add_o !== 32'h0) begin bad++; $display("FAIL reset_add got=%h want=0", tcdm_add_o); end
    total++; if (tcdm_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", tcdm_data_o); end
    total++; if (stall_cnt_o !== 32'h0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    int dc, fd; bit bs, to;
    gnt_mode = 0; proto_err = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      mem[32'(4 * i)] = 32'h0000_00A0 + 32'(i);
      exp_q.push_back(32'h0000_00A0 + 32'(i));
    end
    clear_dst(32'h1000, 4);
    run_copy(32'h0, 32'h1000, 4, -1, 0, dc, fd, bs, to);
    total++; if (to || dc != 1) begin bad++; $display("FAIL basic_done got=%0d timeout=%0d want=1", dc, to); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_mem(32'h1000 + 32'(4 * i)) !== exp_q[i]) begin
        bad++; $display("FAIL basic_word[%0d] got=%h want=%h", i, rd_mem(32'h1000 + 32'(4 * i)), exp_q[i]);
      end
    end
    total++; if (proto_err != 0) begin bad++; $display("FAIL basic_protocol got=%0d want=0", proto_err); end
  endtask

  task automatic test_latency();
    int dc, fd; bit bs, to;
    gnt_mode = 0;
    fill_src(32'h0200, 1);
    clear_dst(32'h0300, 1);
    run_copy(32'h0200, 32'h0300, 1, -1, 0, dc, fd, bs, to);
    total++; if (to || fd < 3 || fd > 5) begin bad++; $display("FAIL latency_len1 got=%0d want=3..5", fd); end
    total++; if (rd_mem(32'h0300) !== exp_q[0]) begin bad++; $display("FAIL latency_word got=%h want=%h", rd_mem(32'h0300), exp_q[0]); end
  endtask

  task automatic test_random();
    int dc, fd, len, nerr; bit bs, to;
    logic [31:0] src, dst;
    gnt_mode = 1;
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? 37 : int'($urandom_range(1, 24));
      // low address bits are randomised: the engine must ignore them
      src = 32'h4000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      dst = 32'h6000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      proto_err = 0; max_occ = 0;
      fill_src(src, len);
      clear_dst(dst, len);
      run_copy(src, dst, len, -1, 0, dc, fd, bs, to);
      total++; if (to || dc != 1) begin bad++; $display("FAIL random_done[%0d] got=%0d timeout=%0d want=1", it, dc, to); end
      nerr = 0;
      for (int i = 0; i < len; i++) begin
        if (rd_mem((dst & 32'hFFFF_FFFC) + 32'(4 * i)) !== exp_q[i]) nerr++;
      end
      total++; if (nerr != 0) begin bad++; $display("FAIL random_words[%0d] got=%0d bad words want=0 (len=%0d)", it, nerr, len); end
      total++; if (proto_err != 0) begin bad++; $display("FAIL random_hold[%0d] got=%0d violations want=0", it, proto_err); end
      total++; if (max_occ > 4) begin bad++; $display("FAIL random_occupancy[%0d] got=%0d want<=4", it, max_occ); end
    end
  endtask

  task automatic test_len0();
    int dc, fd, rq0; bit bs, to;
    gnt_mode = 0;
    rq0 = req_cycles;
    run_copy(32'h0, 32'h1000, 0, -1, 0, dc, fd, bs, to);
    total++; if (req_cycles != rq0) begin bad++; $display("FAIL len0_req got=%0d want=0", req_cycles - rq0); end
    total++; if (fd != 0 || dc != 1) begin bad++; $display("FAIL len0_done got_at=%0d count=%0d want_at=0 count=1", fd, dc); end
    total++; if (bs) begin bad++; $display("FAIL len0_busy got=1 want=0"); end
  endtask

  task automatic test_restart_ignored();
    int dc, fd, wc0; bit bs, to;
    gnt_mode = 1;
    fill_src(32'h3000, 6);
    clear_dst(32'h3800, 8);
    clear_dst(32'hA000, 20);
    wc0 = wr_commits;
    run_copy(32'h3000, 32'h3800, 6, 3, 20, dc, fd, bs, to);
    total++; if (to || dc != 1) begin bad++; $display("FAIL restart_done got=%0d want=1", dc); end
    total++; if (wr_commits - wc0 != 6) begin bad++; $display("FAIL restart_writes got=%0d want=6", wr_commits - wc0); end
    total++; if (mem.exists(32'hA000) || mem.exists(32'h3818)) begin bad++; $display("FAIL restart_stray got=1 want=0"); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rd_mem(32'h3800 + 32'(4 * i)) !== exp_q[i]) begin
        bad++; $display("FAIL restart_word[%0d] got=%h want=%h", i, rd_mem(32'h3800 + 32'(4 * i)), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc, fd, wc0, cyc, nerr; bit bs, to;
    gnt_mode = 0;
    fill_src(32'h5000, 10);
    clear_dst(32'h5800, 10);
    @(negedge clk_i);
    src_addr_i = 32'h5000; dst_addr_i = 32'h5800; len_i = 16'd10; start_i = 1'b1;
    wc0 = wr_commits;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while ((wr_commits - wc0) < 5 && cyc < 500) begin @(negedge clk_i); cyc++; end
    total++; if (cyc >= 500) begin bad++; $display("FAIL rstmid_reach got=%0d writes want=5", wr_commits - wc0); end
    rst_ni = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL rstmid_status got=%b%b want=00", busy_o, done_o); end
    total++; if (tcdm_req_o !== 1'b0 || tcdm_wen_o !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b%b want=01", tcdm_req_o, tcdm_wen_o); end
    total++; if (tcdm_add_o !== 32'h0 || tcdm_data_o !== 32'h0) begin bad++; $display("FAIL rstmid_bus got=%h/%h want=0/0", tcdm_add_o, tcdm_data_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    fill_src(32'h5000, 10);
    run_copy(32'h5000, 32'h5800, 10, -1, 0, dc, fd, bs, to);
    total++; if (to || dc != 1) begin bad++; $display("FAIL rstmid_redo_done got=%0d want=1", dc); end
    nerr = 0;
    for (int i = 0; i < 10; i++) if (rd_mem(32'h5800 + 32'(4 * i)) !== exp_q[i]) nerr++;
    total++; if (nerr != 0) begin bad++; $display("FAIL rstmid_redo_words got=%0d bad words want=0", nerr); end
  endtask

  task automatic test_wrap();
    int dc, fd, nerr; bit bs, to;
    gnt_mode = 1;
    fill_src(32'hFFFF_FFF8, 4);
    clear_dst(32'h2000, 4);
    run_copy(32'hFFFF_FFF8, 32'h2000, 4, -1, 0, dc, fd, bs, to);
    nerr = 0;
    for (int i = 0; i < 4; i++) if (rd_mem(32'h2000 + 32'(4 * i)) !== exp_q[i]) nerr++;
    total++; if (to || nerr != 0) begin bad++; $display("FAIL wrap_words got=%0d bad words want=0", nerr); end
  endtask

  task automatic test_stall();
    int dc, fd; bit bs, to;
    logic [31:0] exp_stall;
`ifdef TCDM_COPY_PERF_EN
    exp_stall = 32'd12;
`else
    exp_stall = 32'd0;
`endif
    gnt_mode = 2;
    fill_src(32'h0700, 2);
    clear_dst(32'h0780, 2);
    run_copy(32'h0700, 32'h0780, 2, -1, 0, dc, fd, bs, to);
    total++; if (to || stall_cnt_o !== exp_stall) begin bad++; $display("FAIL stall_count got=%0d want=%0d", stall_cnt_o, exp_stall); end
    total++; if (rd_mem(32'h0784) !== exp_q[1]) begin bad++; $display("FAIL stall_word got=%h want=%h", rd_mem(32'h0784), exp_q[1]); end
    gnt_mode = 0;
    repeat (4) @(negedge clk_i);
    total++; if (stall_cnt_o !== exp_stall) begin bad++; $display("FAIL stall_hold got=%0d want=%0d", stall_cnt_o, exp_stall); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_random();
    test_len0();
    test_restart_ignored();
    test_reset_mid();
    test_wrap();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
